bcd_minsec_timer: RTL and testbench



---
 rtl/bcd_minsec_timer_pkg.sv | 18 +
 rtl/bcd_minsec_timer_digit.sv | 45 ++++
 rtl/bcd_minsec_timer.sv | 117 +++++++++++
 tb/tb_bcd_minsec_timer.sv | 287 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/bcd_minsec_timer_pkg.sv
// -----------------------------------------------------------------------------
// bcd_minsec_timer_pkg
// Shared definitions for the MM:SS stopwatch: FSM state encoding and the
// per-digit BCD limits used to parameterize each digit counter.
// No ports (package).
// -----------------------------------------------------------------------------
package bcd_minsec_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_RUNNING = 2'd1,
        ST_PAUSED  = 2'd2
    } state_e;

    localparam logic [3:0] UNITS_MAX = 4'd9;
    localparam logic [3:0] TENS_MAX  = 4'd5;

endpackage

// File: rtl/bcd_minsec_timer_digit.sv
// -----------------------------------------------------------------------------
// bcd_digit_counter
// One BCD digit that counts 0..MAX and wraps to 0. Digits are chained by
// feeding carry of one stage into inc of the next.
// Ports:
//   clk    in   system clock
//   reset  in   synchronous active-high reset (digit -> 0)
//   clear  in   synchronous clear (digit -> 0), overrides inc
//   inc    in   increment request for this cycle
//   digit  out  registered BCD value, never above MAX
//   carry  out  combinational: inc while digit is at MAX (wrap this cycle)
// -----------------------------------------------------------------------------
module bcd_digit_counter
    import bcd_minsec_timer_pkg::*;
#(
    parameter logic [3:0] MAX = UNITS_MAX
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear,
    input  logic       inc,
    output logic [3:0] digit,
    output logic       carry
);

    logic [3:0] digit_q, digit_d;

    always_comb begin
        digit_d = digit_q;
        if (clear) begin
            digit_d = '0;
        end else if (inc) begin
            digit_d = (digit_q == MAX) ? 4'd0 : digit_q + 4'd1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) digit_q <= '0;
        else       digit_q <= digit_d;
    end

    assign digit = digit_q;
    assign carry = inc & (digit_q == MAX);

endmodule

// File: rtl/bcd_minsec_timer.sv
// -----------------------------------------------------------------------------
// bcd_minsec_timer
// Free-running MM:SS stopwatch (00:00..59:59) driving four BCD digits.
// A prescaler divides clk into a one-second tick; start_stop rising edges
// toggle run/pause, clear returns to 00:00 and idle.
// Ports:
//   clk         in   system clock
//   reset       in   synchronous active-high reset
//   start_stop  in   debounced button level; rising edge toggles run/pause
//   clear       in   synchronous clear to 00:00 / idle (wins over the button)
//   sec_units   out  BCD 0-9
//   sec_tens    out  BCD 0-5
//   min_units   out  BCD 0-9
//   min_tens    out  BCD 0-5
//   running     out  high while in RUNNING
//   rollover    out  one-cycle pulse on the 59:59 -> 00:00 wrap
// -----------------------------------------------------------------------------
module bcd_minsec_timer
    import bcd_minsec_timer_pkg::*;
#(
    parameter int TICK_DIV = 1000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       start_stop,
    input  logic       clear,
    output logic [3:0] sec_units,
    output logic [3:0] sec_tens,
    output logic [3:0] min_units,
    output logic [3:0] min_tens,
    output logic       running,
    output logic       rollover
);

    localparam int            PW       = $clog2(TICK_DIV);
    localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

    state_e        state_q, state_d;
    logic [PW-1:0] pre_q, pre_d;
    logic          ss_prev_q;
    logic          running_q;
    logic          rollover_q;

    logic ss_edge;
    logic tick;
    logic inc_su;
    logic c_su, c_st, c_mu, c_mt;

    assign ss_edge = start_stop & ~ss_prev_q;
    assign tick    = (state_q == ST_RUNNING) && (pre_q == PRE_LAST);

    // Prescaler and state share one process so clear can override both.
    // The prescaler is evaluated on the current state, so on a pause edge it
    // still advances (or wraps with a tick) before holding in PAUSED.
    always_comb begin
        state_d = state_q;
        pre_d   = pre_q;
        if (clear) begin
            state_d = ST_IDLE;
            pre_d   = '0;
        end else begin
            case (state_q)
                ST_RUNNING: pre_d = tick ? '0 : pre_q + PW'(1);
                ST_IDLE:    pre_d = '0;
                default:    pre_d = pre_q;
            endcase
            if (ss_edge) begin
                case (state_q)
                    ST_IDLE:    state_d = ST_RUNNING;
                    ST_RUNNING: state_d = ST_PAUSED;
                    ST_PAUSED:  state_d = ST_RUNNING;
                    default:    state_d = ST_IDLE;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= ST_IDLE;
            pre_q      <= '0;
            ss_prev_q  <= 1'b1;  // a button held through reset is not an edge
            running_q  <= 1'b0;
            rollover_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            ss_prev_q  <= start_stop;
            running_q  <= (state_d == ST_RUNNING);
            rollover_q <= c_mt;
        end
    end

    // Carry chain resolves the whole cascade combinationally in one cycle.
    assign inc_su = tick & ~clear;

    bcd_digit_counter #(.MAX(UNITS_MAX)) u_sec_units (
        .clk(clk), .reset(reset), .clear(clear), .inc(inc_su),
        .digit(sec_units), .carry(c_su)
    );
    bcd_digit_counter #(.MAX(TENS_MAX)) u_sec_tens (
        .clk(clk), .reset(reset), .clear(clear), .inc(c_su),
        .digit(sec_tens), .carry(c_st)
    );
    bcd_digit_counter #(.MAX(UNITS_MAX)) u_min_units (
        .clk(clk), .reset(reset), .clear(clear), .inc(c_st),
        .digit(min_units), .carry(c_mu)
    );
    bcd_digit_counter #(.MAX(TENS_MAX)) u_min_tens (
        .clk(clk), .reset(reset), .clear(clear), .inc(c_mu),
        .digit(min_tens), .carry(c_mt)
    );

    assign running  = running_q;
    assign rollover = rollover_q;

endmodule

// File: tb/tb_bcd_minsec_timer.sv
// -----------------------------------------------------------------------------
// tb_bcd_minsec_timer
// Self-checking bench for bcd_minsec_timer with TICK_DIV = 4. The reference
// model keeps elapsed time as a plain seconds count plus a go/stop flag and
// derives the expected MM:SS digits arithmetically.
// -----------------------------------------------------------------------------
module tb_bcd_minsec_timer;

    localparam int TD = 4;

    logic       clk;
    logic       reset;
    logic       start_stop;
    logic       clear;
    logic [3:0] sec_units, sec_tens, min_units, min_tens;
    logic       running;
    logic       rollover;
    logic [15:0] dig;

    int checks = 0;
    int errors = 0;

    // reference model state
    int m_secs  = 0;
    int m_pre   = 0;
    bit m_going = 0;
    bit m_prev  = 1;
    bit m_roll  = 0;

    bcd_minsec_timer #(.TICK_DIV(TD)) dut (
        .clk(clk), .reset(reset), .start_stop(start_stop), .clear(clear),
        .sec_units(sec_units), .sec_tens(sec_tens),
        .min_units(min_units), .min_tens(min_tens),
        .running(running), .rollover(rollover)
    );

    assign dig = {min_tens, min_units, sec_tens, sec_units};

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    function automatic logic [15:0] exp_dig();
        return {4'(m_secs / 600), 4'((m_secs / 60) % 10),
                4'((m_secs / 10) % 6), 4'(m_secs % 10)};
    endfunction

    // Drive one cycle, advance the model across the edge, settle 1 time unit.
    task automatic step(input bit r, input bit ss, input bit c);
        bit e;
        reset = r; start_stop = ss; clear = c;
        @(posedge clk);
        if (r) begin
            m_secs = 0; m_pre = 0; m_going = 0; m_prev = 1; m_roll = 0;
        end else begin
            e = ss && !m_prev;
            m_prev = ss;
            m_roll = 0;
            if (c) begin
                m_secs = 0; m_pre = 0; m_going = 0;
            end else begin
                if (m_going) begin
                    if (m_pre == TD - 1) begin
                        m_pre  = 0;
                        m_secs = (m_secs + 1) % 3600;
                        m_roll = (m_secs == 0);
                    end else begin
                        m_pre++;
                    end
                end
                if (e) m_going = !m_going;
            end
        end
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) step(1, 1, 0);
        checks++;
        if (dig !== 16'h0000 || running !== 1'b0 || rollover !== 1'b0) begin
            errors++;
            $display("FAIL reset_state got dig=%h run=%b roll=%b exp 0000/0/0", dig, running, rollover);
        end
        for (int i = 0; i < 3; i++) step(0, 1, 0);
        checks++;
        if (running !== 1'b0 || dig !== 16'h0000) begin
            errors++;
            $display("FAIL reset_held_button got run=%b dig=%h exp 0/0000", running, dig);
        end
    endtask

    task automatic test_start();
        step(0, 0, 0);
        step(0, 1, 0);
        checks++;
        if (running !== 1'b1) begin
            errors++;
            $display("FAIL start_running got %b exp 1", running);
        end
        for (int i = 0; i < 3; i++) step(0, 1, 0);
        checks++;
        if (dig !== 16'h0000) begin
            errors++;
            $display("FAIL start_early_tick got %h exp 0000", dig);
        end
        step(0, 1, 0);
        checks++;
        if (dig !== 16'h0001) begin
            errors++;
            $display("FAIL start_first_tick got %h exp 0001", dig);
        end
        for (int i = 0; i < TD; i++) step(0, 1, 0);
        checks++;
        if (dig !== 16'h0002) begin
            errors++;
            $display("FAIL start_second_tick got %h exp 0002", dig);
        end
    endtask

    task automatic test_carries();
        for (int n = 0; n < 100 && m_secs != 9; n++) step(0, 1, 0);
        checks++;
        if (dig !== 16'h0009) begin
            errors++;
            $display("FAIL carry_pre_0009 got %h exp 0009", dig);
        end
        for (int n = 0; n < TD && m_secs == 9; n++) step(0, 1, 0);
        checks++;
        if (dig !== 16'h0010) begin
            errors++;
            $display("FAIL carry_sec_tens got %h exp 0010", dig);
        end
        for (int n = 0; n < 3000 && m_secs != 599; n++) step(0, 1, 0);
        checks++;
        if (dig !== 16'h0959) begin
            errors++;
            $display("FAIL carry_pre_0959 got %h exp 0959", dig);
        end
        for (int n = 0; n < TD && m_secs == 599; n++) step(0, 1, 0);
        checks++;
        if (dig !== 16'h1000 || running !== 1'b1) begin
            errors++;
            $display("FAIL carry_full_cascade got %h run=%b exp 1000/1", dig, running);
        end
    endtask

    // Entered right after a tick, so the prescaler is at 0.
    task automatic test_pause_resume();
        logic [15:0] saved;
        step(0, 0, 0);
        step(0, 1, 0);  // pause edge, two prescaler counts taken
        saved = dig;
        checks++;
        if (running !== 1'b0 || saved !== 16'h1000) begin
            errors++;
            $display("FAIL pause_enter got run=%b dig=%h exp 0/1000", running, saved);
        end
        for (int i = 0; i < 20; i++) begin
            step(0, 1, 0);
            checks++;
            if (dig !== saved || running !== 1'b0) begin
                errors++;
                $display("FAIL pause_hold cycle %0d got dig=%h run=%b exp %h/0", i, dig, running, saved);
            end
        end
        step(0, 0, 0);
        step(0, 1, 0);
        checks++;
        if (running !== 1'b1 || dig !== saved) begin
            errors++;
            $display("FAIL resume_edge got run=%b dig=%h exp 1/%h", running, dig, saved);
        end
        step(0, 1, 0);
        checks++;
        if (dig !== 16'h1000) begin
            errors++;
            $display("FAIL resume_partial got %h exp 1000", dig);
        end
        step(0, 1, 0);
        checks++;
        if (dig !== 16'h1001) begin
            errors++;
            $display("FAIL resume_tick got %h exp 1001", dig);
        end
    endtask

    task automatic test_rollover();
        for (int n = 0; n < 16000 && m_secs != 3598; n++) step(0, 1, 0);
        checks++;
        if (dig !== 16'h5958 || running !== 1'b1) begin
            errors++;
            $display("FAIL roll_pre_5958 got %h run=%b exp 5958/1", dig, running);
        end
        for (int n = 0; n < TD && m_secs == 3598; n++) step(0, 1, 0);
        checks++;
        if (dig !== 16'h5959 || rollover !== 1'b0) begin
            errors++;
            $display("FAIL roll_5959 got %h roll=%b exp 5959/0", dig, rollover);
        end
        for (int n = 0; n < TD && m_secs == 3599; n++) step(0, 1, 0);
        checks++;
        if (dig !== 16'h0000 || rollover !== 1'b1 || running !== 1'b1) begin
            errors++;
            $display("FAIL roll_wrap got %h roll=%b run=%b exp 0000/1/1", dig, rollover, running);
        end
        step(0, 1, 0);
        checks++;
        if (rollover !== 1'b0 || running !== 1'b1) begin
            errors++;
            $display("FAIL roll_pulse_width got roll=%b run=%b exp 0/1", rollover, running);
        end
    endtask

    task automatic test_clear_with_edge();
        for (int n = 0; n < 2000 && m_secs != 206; n++) step(0, 1, 0);
        for (int n = 0; n < TD + 1 && m_secs == 206; n++) step(0, 0, 0);
        checks++;
        if (dig !== 16'h0327 || running !== 1'b1) begin
            errors++;
            $display("FAIL clear_pre_0327 got %h run=%b exp 0327/1", dig, running);
        end
        step(0, 1, 1);  // clear together with a button edge
        checks++;
        if (dig !== 16'h0000 || running !== 1'b0) begin
            errors++;
            $display("FAIL clear_edge got %h run=%b exp 0000/0", dig, running);
        end
        for (int i = 0; i < 3; i++) step(0, 1, 0);
        checks++;
        if (running !== 1'b0 || dig !== 16'h0000) begin
            errors++;
            $display("FAIL clear_edge_discarded got run=%b dig=%h exp 0/0000", running, dig);
        end
        step(0, 0, 0);
        step(0, 1, 0);
        checks++;
        if (running !== 1'b1) begin
            errors++;
            $display("FAIL clear_restart got %b exp 1", running);
        end
        for (int i = 0; i < TD - 1; i++) step(0, 1, 0);
        checks++;
        if (dig !== 16'h0000) begin
            errors++;
            $display("FAIL clear_restart_early got %h exp 0000", dig);
        end
        step(0, 1, 0);
        checks++;
        if (dig !== 16'h0001) begin
            errors++;
            $display("FAIL clear_restart_tick got %h exp 0001", dig);
        end
    endtask

    task automatic test_random();
        bit ss, r, c;
        ss = 1'b1;
        step(1, ss, 0);
        for (int i = 0; i < 4000; i++) begin
            r = ($urandom_range(0, 499) == 0);
            c = ($urandom_range(0, 63) == 0);
            if ($urandom_range(0, 7) == 0) ss = ~ss;
            step(r, ss, c);
            checks++;
            if (dig !== exp_dig() || running !== m_going || rollover !== m_roll) begin
                errors++;
                $display("FAIL random cycle %0d got dig=%h run=%b roll=%b exp %h/%b/%b",
                         i, dig, running, rollover, exp_dig(), m_going, m_roll);
            end
        end
    endtask

    initial begin
        reset = 1'b1; start_stop = 1'b1; clear = 1'b0;
        test_reset();
        test_start();
        test_carries();
        test_pause_resume();
        test_rollover();
        test_clear_with_edge();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
